// File: rtl/mux_4_1_pkg.sv
// Shared constants and select encoding for the registered 4-to-1 selector.
// Imported by the lane-select slice and the registered top.
package mux_4_1_pkg;

  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_L0 = 2'd0,
    SEL_L1 = 2'd1,
    SEL_L2 = 2'd2,
    SEL_L3 = 2'd3
  } sel_e;

endpackage

// File: rtl/mux_4_1_sel.sv
// Combinational lane picker: returns the lane of i_data chosen by i_sel.
// An unresolvable select falls to the default branch and yields zero.
module mux_4_1_sel
  import mux_4_1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [N_LANES*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]         i_sel,
  output logic [WIDTH-1:0]         o_sel_lane
);

  sel_e w_sel;

  assign w_sel = sel_e'(i_sel);

  always_comb begin
    o_sel_lane = '0;
    unique case (w_sel)
      SEL_L0:  o_sel_lane = i_data[0*WIDTH +: WIDTH];
      SEL_L1:  o_sel_lane = i_data[1*WIDTH +: WIDTH];
      SEL_L2:  o_sel_lane = i_data[2*WIDTH +: WIDTH];
      SEL_L3:  o_sel_lane = i_data[3*WIDTH +: WIDTH];
      default: o_sel_lane = '0;
    endcase
  end

endmodule

// File: rtl/mux_4_1.sv
// Registered 4-to-1 selector with a one-cycle valid-qualified output.
// Y keeps its last selected lane while no valid item arrives.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_LANES*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         Y,
  output logic                     out_valid
);

  logic [WIDTH-1:0] w_sel_lane;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;

  mux_4_1_sel #(
    .WIDTH      (WIDTH)
  ) u_sel (
    .i_data     (data),
    .i_sel      (sel),
    .o_sel_lane (w_sel_lane)
  );

  // Reset wins over any item presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y <= w_sel_lane;
      end
    end
  end

  assign Y         = r_y;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_4_1.sv
// Scoreboard bench for mux_4_1 at WIDTH=1 and WIDTH=8.
// Stimulus pushes expected lanes; a negedge monitor pops and compares.
module tb_mux_4_1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  data1;
  logic [31:0] data8;
  logic [1:0]  sel;
  logic        in_valid;
  logic        y1;
  logic [7:0]  y8;
  logic        ov1;
  logic        ov8;

  int checks = 0;
  int errors = 0;

  logic       q1[$];
  logic [7:0] q8[$];
  logic       mdl_v  = 1'b0;
  logic       mdl_y1 = 1'b0;
  logic [7:0] mdl_y8 = 8'h00;
  bit         started = 1'b0;

  mux_4_1 #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data1),
    .sel       (sel),
    .in_valid  (in_valid),
    .Y         (y1),
    .out_valid (ov1)
  );

  mux_4_1 #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data8),
    .sel       (sel),
    .in_valid  (in_valid),
    .Y         (y8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: lane s of a packed word is (word >> s*W) masked to W bits.
  task automatic drive(input logic r, input logic [3:0] d1,
                       input logic [31:0] d8, input logic [1:0] s,
                       input logic v);
    logic       e1;
    logic [7:0] e8;
    rst_n    = r;
    data1    = d1;
    data8    = d8;
    sel      = s;
    in_valid = v;
    e1 = 1'((d1 >> s) & 4'h1);
    e8 = 8'((d8 >> (int'(s) * 8)) & 32'hFF);
    @(posedge clk);
    if (!r) begin
      mdl_v  = 1'b0;
      mdl_y1 = 1'b0;
      mdl_y8 = 8'h00;
    end else begin
      mdl_v = v;
      if (v) begin
        mdl_y1 = e1;
        mdl_y8 = e8;
        q1.push_back(e1);
        q8.push_back(e8);
      end
    end
    started = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (ov1 !== mdl_v) begin
        errors++;
        $display("FAIL valid_w1: got %b expected %b t=%0t", ov1, mdl_v, $time);
      end
      checks++;
      if (ov8 !== mdl_v) begin
        errors++;
        $display("FAIL valid_w8: got %b expected %b t=%0t", ov8, mdl_v, $time);
      end
      if (ov1 === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL y_w1: output with empty queue, got %b t=%0t", y1, $time);
        end else begin
          logic e;
          e = q1.pop_front();
          if (y1 !== e) begin
            errors++;
            $display("FAIL y_w1: got %b expected %b t=%0t", y1, e, $time);
          end
        end
      end else begin
        checks++;
        if (y1 !== mdl_y1) begin
          errors++;
          $display("FAIL hold_w1: got %b expected %b t=%0t", y1, mdl_y1, $time);
        end
      end
      if (ov8 === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL y_w8: output with empty queue, got %h t=%0t", y8, $time);
        end else begin
          logic [7:0] e;
          e = q8.pop_front();
          if (y8 !== e) begin
            errors++;
            $display("FAIL y_w8: got %h expected %h t=%0t", y8, e, $time);
          end
        end
      end else begin
        checks++;
        if (y8 !== mdl_y8) begin
          errors++;
          $display("FAIL hold_w8: got %h expected %h t=%0t", y8, mdl_y8, $time);
        end
      end
    end
  end

  localparam logic [31:0] PAT8 = 32'hDDCC_BBAA;

  initial begin
    rst_n    = 1'b0;
    data1    = 4'h0;
    data8    = 32'h0;
    sel      = 2'd0;
    in_valid = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b0, 4'hF, 32'hFFFF_FFFF, 2'd3, 1'b1);
    drive(1'b1, 4'hF, PAT8, 2'd3, 1'b1);

    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 16; d++)
        drive(1'b1, 4'(d), $urandom, 2'(s), 1'b1);

    drive(1'b1, 4'b0010, PAT8, 2'd1, 1'b1);
    drive(1'b1, 4'b0000, 32'h0, 2'd1, 1'b0);
    drive(1'b1, 4'b0000, 32'h0, 2'd0, 1'b0);

    for (int i = 0; i < 4; i++)
      drive(1'b1, 4'b1000, PAT8, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b1);

    for (int i = 0; i < 4; i++) drive(1'b1, 4'($urandom), $urandom, 2'($urandom), 1'b1);
    drive(1'b0, 4'hF, 32'hFFFF_FFFF, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'($urandom), $urandom, 2'($urandom), 1'b1);

    for (int s = 0; s < 4; s++) drive(1'b1, 4'h5, PAT8, 2'(s), 1'b1);

    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 19) != 0), 4'($urandom), $urandom,
            2'($urandom), 1'($urandom));

    drive(1'b1, 4'h0, 32'h0, 2'd0, 1'b0);
    drive(1'b1, 4'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    #1;

    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: leftover items w1=%0d w8=%0d expected 0",
               q1.size(), q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
